// File: rtl/mbru_fetch_reg.sv
// Instruction-fetch holding register: captures the IRAM byte on fetch and holds it for decode.
// Also reports whether a byte has been captured since reset and how many captures occurred.
module mbru_fetch_reg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch,
  input  logic [DATA_W-1:0] ins_in,
  output logic [DATA_W-1:0] ins_out,
  output logic              ins_valid,
  output logic [CNT_W-1:0]  fetch_cnt
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] ins_d,   ins_q;
  logic              valid_d, valid_q;
  logic [CNT_W-1:0]  cnt_d,   cnt_q;

  // Hold path selects the stored byte, so an undriven ins_in never leaks through.
  always_comb begin
    ins_d   = ins_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (rst) begin
      ins_d   = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (fetch) begin
      ins_d   = ins_in;
      valid_d = 1'b1;
      cnt_d   = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    ins_q   <= ins_d;
    valid_q <= valid_d;
    cnt_q   <= cnt_d;
  end

  assign ins_out   = ins_q;
  assign ins_valid = valid_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_mbru_fetch_reg.sv
// Self-checking bench for mbru_fetch_reg: directed scenarios plus randomized traffic
// compared against a simple register-transfer reference model.
module tb_mbru_fetch_reg;

  logic       clk;
  logic       rst;
  logic       fetch;
  logic [7:0] ins_in;
  logic [7:0] ins_out;
  logic       ins_valid;
  logic [7:0] fetch_cnt;

  // Reference model state
  logic [7:0] m_out;
  logic       m_valid;
  int         m_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  mbru_fetch_reg #(
    .DATA_W(8),
    .CNT_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch    (fetch),
    .ins_in   (ins_in),
    .ins_out  (ins_out),
    .ins_valid(ins_valid),
    .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag);
    logic [7:0] exp_cnt;
    exp_cnt = 8'(m_cnt % 256);
    n_cmp++;
    assert (ins_out === m_out) else begin
      n_bad++;
      $error("FAIL %s ins_out: observed %h expected %h", tag, ins_out, m_out);
    end
    n_cmp++;
    assert (ins_valid === m_valid) else begin
      n_bad++;
      $error("FAIL %s ins_valid: observed %b expected %b", tag, ins_valid, m_valid);
    end
    n_cmp++;
    assert (fetch_cnt === exp_cnt) else begin
      n_bad++;
      $error("FAIL %s fetch_cnt: observed %h expected %h", tag, fetch_cnt, exp_cnt);
    end
  endtask

  // Drive one cycle of inputs, advance the model by the same edge, then check.
  task automatic step(input logic r, input logic f, input logic [7:0] d, input string tag);
    rst    = r;
    fetch  = f;
    ins_in = d;
    @(posedge clk);
    if (r) begin
      m_out   = 8'h00;
      m_valid = 1'b0;
      m_cnt   = 0;
    end else if (f) begin
      m_out   = d;
      m_valid = 1'b1;
      m_cnt   = (m_cnt + 1) % 256;
    end
    #1;
    check(tag);
  endtask

  initial begin
    rst    = 1'b0;
    fetch  = 1'b0;
    ins_in = 8'h00;
    m_out   = 8'h00;
    m_valid = 1'b0;
    m_cnt   = 0;
    @(negedge clk);

    // 1: reset wins over fetch
    step(1'b1, 1'b1, 8'hA5, "reset0");
    step(1'b1, 1'b1, 8'hA5, "reset1");

    // 2: back-to-back capture of an incrementing source
    for (int n = 0; n < 10; n++) step(1'b0, 1'b1, 8'(n), "stream");

    // 3: hold keeps byte and count, even with X on ins_in
    step(1'b0, 1'b1, 8'h3C, "cap3c");
    for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 8'hFF, "hold");
    step(1'b0, 1'b0, 8'bx, "hold_x");
    step(1'b0, 1'b0, 8'bx, "hold_x");

    // 4: full sweep; counter and data both wrap
    step(1'b1, 1'b0, 8'h00, "rst_sweep");
    for (int n = 0; n < 256; n++) step(1'b0, 1'b1, 8'(n), "sweep");
    step(1'b0, 1'b1, 8'h00, "wrap");

    // 5: reset in a fetch cycle discards the byte
    step(1'b1, 1'b1, 8'h77, "rst_fetch");
    step(1'b0, 1'b0, 8'h77, "after_rst");

    // 6: alternating fetch with incrementing source -> even values only
    for (int c = 0; c < 12; c++) step(1'b0, (c % 2) == 0, 8'(c), "alt");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic f;
      r = ($urandom_range(0, 19) == 0);
      f = $urandom_range(0, 1) == 1;
      step(r, f, 8'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
